// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side byte handshake and status bundle driven by uart_rx.
interface uart_rx_if #(parameter int DATA_BITS = 8);
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;
   logic                 frame_err;
   logic                 overrun;
   logic                 busy;
   modport master (output data, valid, frame_err, overrun, busy, input ready);
   modport slave  (input data, valid, frame_err, overrun, busy, output ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampled mid-bit UART receiver (start, MSB-first data, stop) with one-entry valid/ready output.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting per bit (decisions one clock later).
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     din,
   uart_rx_if.master rx
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] MID      = TW'(CLKS_PER_BIT/2-1);
   localparam logic [TW-1:0] LAST     = TW'(CLKS_PER_BIT-1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS-1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
   state_t               state_q, state_d;
   logic                 sync_q, rx_s_q;
   logic [TW-1:0]        timer_q, timer_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
   logic                 valid_q, valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d, busy_q, busy_d;
   logic                 samp, start_tick, bit_tick;
   logic [TW-1:0]        timer_start;
`ifdef UART_RX_MAJORITY_EN
   logic s1_q, s2_q;
   // Vote over ref-1/ref/ref+1; timer restarts at 1 so later refs stay aligned with the unvoted timing.
   assign samp        = (s2_q & s1_q) | (s2_q & rx_s_q) | (s1_q & rx_s_q);
   assign start_tick  = timer_q == MID + TW'(1);
   assign bit_tick    = timer_q == '0;
   assign timer_start = TW'(1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= rx_s_q;
         s2_q <= s1_q;
      end
`else
   assign samp        = rx_s_q;
   assign start_tick  = timer_q == MID;
   assign bit_tick    = timer_q == LAST;
   assign timer_start = '0;
`endif
   always_comb begin
      state_d     = state_q;
      timer_d     = (timer_q == LAST) ? '0 : timer_q + TW'(1);
      bit_d       = bit_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = valid_q && !rx.ready;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            state_d = rx_s_q ? IDLE : START;
         end
         START: if (start_tick) begin
            state_d = samp ? IDLE : DATA;
            timer_d = timer_start;
            bit_d   = '0;
         end
         DATA: if (bit_tick) begin
            shift_d = {shift_q[DATA_BITS-2:0], samp};
            bit_d   = bit_q + BW'(1);
            state_d = (bit_q == LAST_BIT) ? STOP : DATA;
         end
         STOP: if (bit_tick) begin
            state_d     = samp ? IDLE : WAIT_HI;
            frame_err_d = !samp;
            // A same-cycle consume frees the slot, so the new byte loads instead of overrunning.
            if (samp && (!valid_q || rx.ready)) begin
               data_d  = shift_q;
               valid_d = 1'b1;
            end
            overrun_d = samp && valid_q && !rx.ready;
         end
         WAIT_HI: state_d = rx_s_q ? IDLE : WAIT_HI;
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= IDLE;
         sync_q      <= 1'b1;
         rx_s_q      <= 1'b1;
         timer_q     <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= din;
         rx_s_q      <= sync_q;
         timer_q     <= timer_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   assign rx.data      = data_q;
   assign rx.valid     = valid_q;
   assign rx.frame_err = frame_err_q;
   assign rx.overrun   = overrun_q;
   assign rx.busy      = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx; a queue scoreboard checks each accepted byte.
module tb_uart_rx;
   localparam int CPB = 16;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic din = 1'b1;
   uart_rx_if #(.DATA_BITS(8)) rx_if ();
   uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (.clk(clk), .rst_n(rst_n), .din(din), .rx(rx_if));
   always #5 clk = ~clk;
   logic [7:0] sb_q[$];
   int vectors = 0;
   int errs = 0;
   int valid_cycles = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   always @(negedge clk) if (rst_n) begin
      if (rx_if.valid) valid_cycles++;
      if (rx_if.frame_err) fe_cnt++;
      if (rx_if.overrun) ov_cnt++;
      if (rx_if.valid && rx_if.ready) begin
         vectors++;
         if (sb_q.size() == 0) begin
            errs++;
            $display("FAIL rx_byte: got %02h, scoreboard expected nothing", rx_if.data);
         end else begin
            logic [7:0] e;
            e = sb_q.pop_front();
            if (rx_if.data !== e) begin
               errs++;
               $display("FAIL rx_byte: got %02h expected %02h", rx_if.data, e);
            end
         end
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic drive(input logic v);
      din = v;
      tick(CPB);
   endtask
   task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit glitch);
      drive(1'b0);
      for (int i = 7; i >= 0; i--)
         if (glitch && i == 7) begin
            din = b[i];
            tick(CPB/2);
            din = ~b[i];
            tick(1);
            din = b[i];
            tick(CPB/2-1);
         end else drive(b[i]);
      drive(stop_v);
   endtask
   task automatic clr;
      valid_cycles = 0;
      fe_cnt = 0;
      ov_cnt = 0;
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      bit gl;
      bit fell;
`ifdef UART_RX_MAJORITY_EN
      gl = 1'b1;
`else
      gl = 1'b0;
`endif
      rx_if.ready = 1'b1;
      tick(4);
      #2;
      chk("reset_data", rx_if.data, 0);
      chk("reset_valid", rx_if.valid, 0);
      chk("reset_frame_err", rx_if.frame_err, 0);
      chk("reset_overrun", rx_if.overrun, 0);
      chk("reset_busy", rx_if.busy, 0);
      rst_n = 1'b1;
      tick(2 * CPB);
      // basic frame, consumer always ready
      clr();
      sb_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0);
      tick(2 * CPB);
      chk("t1_valid_cycles", valid_cycles, 1);
      chk("t1_frame_err", fe_cnt, 0);
      chk("t1_overrun", ov_cnt, 0);
      // false start: 4-clock low pulse
      clr();
      din = 1'b0;
      tick(4);
      chk("t2_busy_during", rx_if.busy, 1);
      din = 1'b1;
      fell = 1'b0;
      for (int i = 0; i < 10 && !fell; i++) begin
         tick(1);
         fell = !rx_if.busy;
      end
      chk("t2_busy_fell", fell, 1);
      tick(CPB);
      chk("t2_valid_cycles", valid_cycles, 0);
      chk("t2_frame_err", fe_cnt, 0);
      // framing error, then recovery
      clr();
      send_frame(8'h5A, 1'b0, 1'b0);
      din = 1'b1;
      tick(2 * CPB);
      chk("t3_frame_err_cycles", fe_cnt, 1);
      chk("t3_valid_cycles", valid_cycles, 0);
      clr();
      sb_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, 1'b0);
      tick(2 * CPB);
      chk("t3_next_valid_cycles", valid_cycles, 1);
      // overrun with consumer stalled
      clr();
      rx_if.ready = 1'b0;
      sb_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, 1'b0);
      send_frame(8'hC3, 1'b1, 1'b0);
      tick(2 * CPB);
      chk("t4_valid_held", rx_if.valid, 1);
      chk("t4_data_held", rx_if.data, 8'h3C);
      chk("t4_overrun_cycles", ov_cnt, 1);
      rx_if.ready = 1'b1;
      tick(1);
      chk("t4_valid_cleared", rx_if.valid, 0);
      // reset in the middle of 0xFF
      drive(1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1);
      tick(5);
      rst_n = 1'b0;
      din = 1'b1;
      tick(3);
      #2;
      chk("t5_data", rx_if.data, 0);
      chk("t5_valid", rx_if.valid, 0);
      chk("t5_frame_err", rx_if.frame_err, 0);
      chk("t5_overrun", rx_if.overrun, 0);
      chk("t5_busy", rx_if.busy, 0);
      rst_n = 1'b1;
      tick(2 * CPB);
      clr();
      sb_q.push_back(8'h12);
      send_frame(8'h12, 1'b1, 1'b0);
      tick(2 * CPB);
      chk("t5_next_valid_cycles", valid_cycles, 1);
      // loopback-style stream with 16 idle clocks between frames
      clr();
      sb_q.push_back(8'h00);
      send_frame(8'h00, 1'b1, gl);
      tick(CPB);
      sb_q.push_back(8'h7E);
      send_frame(8'h7E, 1'b1, 1'b0);
      tick(CPB);
      sb_q.push_back(8'hFF);
      send_frame(8'hFF, 1'b1, 1'b0);
      tick(2 * CPB);
      chk("t6_valid_cycles", valid_cycles, 3);
      chk("t6_flags", fe_cnt + ov_cnt, 0);
      chk("sb_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
